// File: rtl/cond_pkg.sv
// Shared encodings for ARM condition evaluation: condition codes, flag bit
// positions within the NZCV register, and the handshake FSM states.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator: {cond, nzcv} -> {pass, bad}.
// NV (4'b1111) never passes and is flagged as a bad condition.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass,
  output logic       bad
);

  logic n, z, c, v;

  assign n = nzcv[FLG_N];
  assign z = nzcv[FLG_Z];
  assign c = nzcv[FLG_C];
  assign v = nzcv[FLG_V];

  always_comb begin
    pass = 1'b0;
    bad  = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: bad  = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_check_unit.sv
// Condition check unit: samples COND and an NZCV snapshot on request, returns
// pass/fail over a valid/ack handshake and keeps saturating statistics.
// Optional macro COND_FLAG_BYPASS_EN forwards FLAG_D into the snapshot when FLAG_WE=1.
module cond_check_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             REQ,
  input  logic [3:0]       COND,
  input  logic [3:0]       FLAGS,
  input  logic             FLAG_WE,
  input  logic [3:0]       FLAG_D,
  input  logic             ACK,
  output logic             BUSY,
  output logic             VALID,
  output logic             COND_PASS,
  output logic             BAD_COND,
  output logic [CNT_W-1:0] PASS_CNT,
  output logic [CNT_W-1:0] FAIL_CNT
);

  state_t     state;
  logic [3:0] cond_p0;
  logic [3:0] flags_p0;
  logic [3:0] snap;
  logic       sample;
  logic       pass_c;
  logic       bad_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + CNT_W'(1);
  endfunction

`ifdef COND_FLAG_BYPASS_EN
  assign snap = FLAG_WE ? FLAG_D : FLAGS;
`else
  logic unused_bypass;
  assign snap          = FLAGS;
  assign unused_bypass = ^{FLAG_WE, FLAG_D};
`endif

  // Requests are taken from IDLE, or from RESP when the result is acked the same edge
  assign sample = REQ && ((state == ST_IDLE) || ((state == ST_RESP) && ACK));

  // Stage p0: condition and flag snapshot, frozen until the next accepted request
  always_ff @(posedge CLK) begin
    if (sample) begin
      cond_p0  <= COND;
      flags_p0 <= snap;
    end
  end

  cond_eval u_eval (
    .cond (cond_p0),
    .nzcv (flags_p0),
    .pass (pass_c),
    .bad  (bad_c)
  );

  // Stage p1: registered result and handshake FSM
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= ST_IDLE;
      BUSY      <= 1'b0;
      VALID     <= 1'b0;
      COND_PASS <= 1'b0;
      BAD_COND  <= 1'b0;
      PASS_CNT  <= '0;
      FAIL_CNT  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ) begin
            state <= ST_EVAL;
            BUSY  <= 1'b1;
          end
        end
        ST_EVAL: begin
          COND_PASS <= pass_c;
          BAD_COND  <= bad_c;
          VALID     <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (ACK) begin
            VALID <= 1'b0;
            if (COND_PASS) PASS_CNT <= sat_inc(PASS_CNT);
            else           FAIL_CNT <= sat_inc(FAIL_CNT);
            if (REQ) begin
              state <= ST_EVAL;
            end else begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
          VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cond_check_unit.sv
// Self-checking bench for cond_check_unit: directed vectors, exhaustive sweep,
// handshake corner cases and randomized transactions against a reference model.
module tb_cond_check_unit;
  import cond_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             reset;
  logic             REQ;
  logic [3:0]       COND;
  logic [3:0]       FLAGS;
  logic             FLAG_WE;
  logic [3:0]       FLAG_D;
  logic             ACK;
  logic             BUSY;
  logic             VALID;
  logic             COND_PASS;
  logic             BAD_COND;
  logic [CNT_W-1:0] PASS_CNT;
  logic [CNT_W-1:0] FAIL_CNT;

  cond_check_unit #(.CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .REQ       (REQ),
    .COND      (COND),
    .FLAGS     (FLAGS),
    .FLAG_WE   (FLAG_WE),
    .FLAG_D    (FLAG_D),
    .ACK       (ACK),
    .BUSY      (BUSY),
    .VALID     (VALID),
    .COND_PASS (COND_PASS),
    .BAD_COND  (BAD_COND),
    .PASS_CNT  (PASS_CNT),
    .FAIL_CNT  (FAIL_CNT)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  int m_pass_cnt = 0;
  int m_fail_cnt = 0;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       pass;
    logic       bad;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: the condition family is cond[3:1]; cond[0] inverts it, except NV.
  function automatic logic [1:0] ref_eval(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, r;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    if (c == 4'hF) return 2'b01;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0]) r = !r;
    return {r, 1'b0};
  endfunction

  function automatic logic [3:0] snap_ref(input logic [3:0] f, input logic we, input logic [3:0] d);
`ifdef COND_FLAG_BYPASS_EN
    return we ? d : f;
`else
    return f;
`endif
  endfunction

  task automatic model_ack(input logic p);
    if (p) m_pass_cnt = (m_pass_cnt < CNT_MAX) ? m_pass_cnt + 1 : CNT_MAX;
    else   m_fail_cnt = (m_fail_cnt < CNT_MAX) ? m_fail_cnt + 1 : CNT_MAX;
  endtask

  task automatic chk_cnts(input string nm);
    chk({nm, "_pass_cnt"}, 32'(PASS_CNT), 32'(m_pass_cnt));
    chk({nm, "_fail_cnt"}, 32'(FAIL_CNT), 32'(m_fail_cnt));
  endtask

  task automatic do_reset();
    reset = 1'b1; REQ = 1'b0; ACK = 1'b0;
    step();
    reset = 1'b0;
    m_pass_cnt = 0;
    m_fail_cnt = 0;
  endtask

  // Full transaction from IDLE: request, two edges to VALID, optional ack delay, ack.
  task automatic txn(input string nm, input logic [3:0] c, input logic [3:0] f,
                     input logic we, input logic [3:0] d,
                     input logic ep, input logic eb, input int ack_wait);
    COND = c; FLAGS = f; FLAG_WE = we; FLAG_D = d; REQ = 1'b1;
    step();
    chk({nm, "_busy_eval"}, 32'(BUSY), 32'd1);
    chk({nm, "_valid_eval"}, 32'(VALID), 32'd0);
    REQ = 1'b0; COND = 4'($urandom); FLAGS = 4'($urandom);
    FLAG_WE = 1'($urandom); FLAG_D = 4'($urandom);
    step();
    chk({nm, "_valid"}, 32'(VALID), 32'd1);
    chk({nm, "_pass"}, 32'(COND_PASS), 32'(ep));
    chk({nm, "_bad"}, 32'(BAD_COND), 32'(eb));
    for (int i = 0; i < ack_wait; i++) begin
      FLAGS = 4'($urandom); COND = 4'($urandom);
      step();
      chk({nm, "_hold_valid"}, 32'(VALID), 32'd1);
      chk({nm, "_hold_pass"}, 32'(COND_PASS), 32'(ep));
    end
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    model_ack(ep);
    chk({nm, "_valid_after_ack"}, 32'(VALID), 32'd0);
    chk({nm, "_busy_after_ack"}, 32'(BUSY), 32'd0);
    chk_cnts(nm);
  endtask

  initial begin
    logic [1:0] e;
    logic       hp;
    logic [3:0] hc;

    vecs[0] = '{cond: COND_GT, flags: 4'b1001, pass: 1'b1, bad: 1'b0};
    vecs[1] = '{cond: COND_GE, flags: 4'b1000, pass: 1'b0, bad: 1'b0};
    vecs[2] = '{cond: COND_NV, flags: 4'b0110, pass: 1'b0, bad: 1'b1};
    vecs[3] = '{cond: COND_EQ, flags: 4'b0100, pass: 1'b1, bad: 1'b0};
    vecs[4] = '{cond: COND_HI, flags: 4'b0010, pass: 1'b1, bad: 1'b0};
    vecs[5] = '{cond: COND_LS, flags: 4'b0110, pass: 1'b1, bad: 1'b0};

    reset = 1'b1; REQ = 1'b0; ACK = 1'b0; COND = '0; FLAGS = '0;
    FLAG_WE = 1'b0; FLAG_D = '0;
    step(); step();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_pass", 32'(COND_PASS), 32'd0);
    chk("rst_bad", 32'(BAD_COND), 32'd0);
    chk_cnts("rst");
    reset = 1'b0;
    m_pass_cnt = 0; m_fail_cnt = 0;

    // Basic EQ with Z set
    txn("t1", COND_EQ, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0, 0);

    for (int i = 0; i < 6; i++)
      txn("vec", vecs[i].cond, vecs[i].flags, 1'b0, 4'b0000, vecs[i].pass, vecs[i].bad, i % 3);

    do_reset();
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f++) begin
        e = ref_eval(4'(c), 4'(f));
        txn("sweep", 4'(c), 4'(f), 1'b0, 4'b0000, e[1], e[0], 0);
      end

    // Long hold in RESP with noisy inputs
    do_reset();
    COND = COND_EQ; FLAGS = 4'b0100; FLAG_WE = 1'b0; REQ = 1'b1;
    step();
    REQ = 1'b0;
    step();
    chk("hold_valid0", 32'(VALID), 32'd1);
    for (int i = 0; i < 5; i++) begin
      FLAGS = 4'($urandom); COND = 4'($urandom); REQ = 1'($urandom);
      FLAG_WE = 1'($urandom); FLAG_D = 4'($urandom);
      step();
      chk("hold_valid", 32'(VALID), 32'd1);
      chk("hold_pass", 32'(COND_PASS), 32'd1);
      chk("hold_bad", 32'(BAD_COND), 32'd0);
      chk_cnts("hold");
    end
    REQ = 1'b0; ACK = 1'b1;
    step();
    ACK = 1'b0;
    model_ack(1'b1);
    chk_cnts("hold_ack");
    chk("hold_idle", 32'(BUSY), 32'd0);

    // Back-to-back: failing EQ acked together with a new AL request
    COND = COND_EQ; FLAGS = 4'b0000; FLAG_WE = 1'b0; REQ = 1'b1;
    step();
    REQ = 1'b0;
    step();
    chk("b2b_first_pass", 32'(COND_PASS), 32'd0);
    COND = COND_AL; FLAGS = 4'b0000; ACK = 1'b1; REQ = 1'b1;
    step();
    ACK = 1'b0; REQ = 1'b0; COND = COND_NV;
    model_ack(1'b0);
    chk("b2b_busy", 32'(BUSY), 32'd1);
    chk("b2b_valid_gap", 32'(VALID), 32'd0);
    chk_cnts("b2b_first");
    step();
    chk("b2b_busy2", 32'(BUSY), 32'd1);
    chk("b2b_valid", 32'(VALID), 32'd1);
    chk("b2b_pass", 32'(COND_PASS), 32'd1);
    chk("b2b_bad", 32'(BAD_COND), 32'd0);
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    model_ack(1'b1);
    chk_cnts("b2b_second");

    // Fail counter saturation
    do_reset();
    for (int i = 0; i < 17; i++)
      txn("sat", COND_NV, 4'($urandom), 1'b0, 4'b0000, 1'b0, 1'b1, 0);
    chk("sat_fail_max", 32'(FAIL_CNT), 32'(CNT_MAX));

    // Reset during EVAL
    txn("pre_rst", COND_AL, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 0);
    COND = COND_AL; REQ = 1'b1;
    step();
    REQ = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; m_pass_cnt = 0; m_fail_cnt = 0;
    chk("rst_eval_valid", 32'(VALID), 32'd0);
    chk("rst_eval_busy", 32'(BUSY), 32'd0);
    chk_cnts("rst_eval");
    step();
    chk("rst_eval_stay", 32'(VALID), 32'd0);

    // Reset during RESP, counters nonzero beforehand
    txn("pre_rst2", COND_NV, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 0);
    COND = COND_AL; REQ = 1'b1;
    step();
    REQ = 1'b0;
    step();
    chk("rst_resp_valid0", 32'(VALID), 32'd1);
    reset = 1'b1; ACK = 1'b1;
    step();
    reset = 1'b0; ACK = 1'b0; m_pass_cnt = 0; m_fail_cnt = 0;
    chk("rst_resp_valid", 32'(VALID), 32'd0);
    chk("rst_resp_busy", 32'(BUSY), 32'd0);
    chk("rst_resp_pass", 32'(COND_PASS), 32'd0);
    chk_cnts("rst_resp");

    // Flag bypass
    e = ref_eval(COND_EQ, snap_ref(4'b0000, 1'b1, 4'b0100));
`ifdef COND_FLAG_BYPASS_EN
    chk("bypass_model", 32'(e), 32'b10);
`else
    chk("bypass_model", 32'(e), 32'b00);
`endif
    txn("bypass", COND_EQ, 4'b0000, 1'b1, 4'b0100, e[1], e[0], 0);

    // Randomized transactions
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [3:0] rc, rf, rd;
      logic       rw;
      rc = 4'($urandom); rf = 4'($urandom); rd = 4'($urandom); rw = 1'($urandom);
      e = ref_eval(rc, snap_ref(rf, rw, rd));
      txn("rand", rc, rf, rw, rd, e[1], e[0], int'($urandom_range(0, 3)));
    end

    // ACK while idle must be ignored
    hp = 1'b0; hc = 4'($urandom);
    ACK = 1'b1; COND = hc;
    step(); step();
    ACK = 1'b0;
    chk("idle_ack_valid", 32'(VALID), 32'(hp));
    chk_cnts("idle_ack");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
